mdu_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS core, sitting beside the ALU in the Execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations with a one-cycle start handshake, models a configurable multi-cycle latency with a busy counter, and commits results to the HI/LO registers. It also supports a flush that cancels an in-flight operation. The hazard unit uses `stall_req` to freeze F/D and bubble E while the unit is occupied.

---
 rtl/mdu_unit.sv | 176 +++++++++++++++++
 tb/tb_mdu_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit beside the Execute-stage ALU.
// Computes at accept, holds results pending, commits to HI/LO after a fixed latency.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]    MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_1  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic op_signed;

    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] mul_p;

    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    // Opcode decode; reserved and NONE fall through to no action.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        op_signed = 1'b0;
        case (op)
            OP_MULT: begin
                is_mul    = 1'b1;
                op_signed = 1'b1;
            end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV: begin
                is_div    = 1'b1;
                op_signed = 1'b1;
            end
            OP_DIVU: is_div  = 1'b1;
            OP_MTHI: is_mthi = 1'b1;
            OP_MTLO: is_mtlo = 1'b1;
            default: ;
        endcase
    end

    // Full-width product; sign-extending to 2W makes the modular
    // product equal to the signed product.
    always_comb begin
        mul_a = op_signed ? {{WIDTH{a[WIDTH-1]}}, a}
                          : {{WIDTH{1'b0}}, a};
        mul_b = op_signed ? {{WIDTH{b[WIDTH-1]}}, b}
                          : {{WIDTH{1'b0}}, b};
        mul_p = mul_a * mul_b;
    end

    // Magnitude divide with sign fix-up: quotient truncates toward
    // zero, remainder follows the dividend. MIN/-1 wraps to MIN, rem 0.
    always_comb begin
        a_neg  = op_signed & a[WIDTH-1];
        b_neg  = op_signed & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = (b == '0);
        b_safe = b_zero ? ONE_W : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    // Stall covers the accept cycle before busy is registered.
    assign stall_req = busy | (start & ~flush & (is_mul | is_div));

    // Accept, countdown, commit and flush of pending results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                cnt     <= '0;
                busy    <= 1'b0;
                pend_hi <= '0;
                pend_lo <= '0;
                pend_wr <= 1'b0;
            end else if (busy) begin
                cnt <= cnt - CNT_1;
                if (cnt == CNT_1) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (pend_wr) begin
                        hi <= pend_hi;
                        lo <= pend_lo;
                    end
                    pend_hi <= '0;
                    pend_lo <= '0;
                    pend_wr <= 1'b0;
                end
            end else if (start) begin
                unique case (1'b1)
                    is_mul: begin
                        cnt     <= MULT_N;
                        busy    <= 1'b1;
                        pend_hi <= mul_p[2*WIDTH-1:WIDTH];
                        pend_lo <= mul_p[WIDTH-1:0];
                        pend_wr <= 1'b1;
                    end
                    is_div: begin
                        cnt     <= DIV_N;
                        busy    <= 1'b1;
                        pend_hi <= rem;
                        pend_lo <= quo;
                        pend_wr <= ~b_zero;
                    end
                    is_mthi: hi <= a;
                    is_mtlo: lo <= a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table for single operations,
// hand sequences for back-to-back moves, flush, start-while-busy, reset.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] eh = '0;
    logic [31:0] el = '0;

    mdu_unit #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .flush(flush),
        .busy(busy),
        .stall_req(stall_req),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wh;
        logic        wl;
        logic [31:0] vh;
        logic [31:0] vl;
        int          n;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic wh,
                         input logic wl, input logic [31:0] vh,
                         input logic [31:0] vl, input int n,
                         input string nm);
        int   cyc;
        logic seen;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        chk({nm, " stall_req"}, 32'(stall_req), 32'(n > 0));
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        cyc = 0;
        seen = 1'b0;
        while (busy && cyc < 64) begin
            cyc++;
            if (done) seen = 1'b1;
            if (cyc == 1) begin
                chk({nm, " hi while busy"}, hi, eh);
                chk({nm, " lo while busy"}, lo, el);
            end
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, cyc, n);
        chk({nm, " early done"}, 32'(seen), 32'(0));
        if (wh) eh = vh;
        if (wl) el = vl;
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        if (n > 0 && (wh || wl))
            chk({nm, " done pulse"}, 32'(done), 32'(1));
        if (n == 0)
            chk({nm, " no done"}, 32'(done), 32'(0));
        @(negedge clk);
        chk({nm, " done cleared"}, 32'(done), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic seen;
        logic chg;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h3, 1, 1,
                     32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h2, 1, 1,
                     32'h1, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 1, 1,
                     32'h40000000, 32'h0, 5};
        vecs[3]  = '{3'd1, 32'h7, 32'hFFFFFFFD, 1, 1,
                     32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[4]  = '{3'd2, 32'h3, 32'h4, 1, 1,
                     32'h0, 32'hC, 5};
        vecs[5]  = '{3'd3, 32'hFFFFFFF9, 32'h2, 1, 1,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[6]  = '{3'd3, 32'h7, 32'hFFFFFFFE, 1, 1,
                     32'h1, 32'hFFFFFFFD, 10};
        vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'h2, 1, 1,
                     32'h1, 32'h7FFFFFFC, 10};
        vecs[8]  = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 1, 1,
                     32'hFFFFFFFE, 32'h2, 10};
        vecs[9]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1, 1,
                     32'h0, 32'h80000000, 10};
        vecs[10] = '{3'd4, 32'h7, 32'h0, 0, 0,
                     32'h0, 32'h0, 10};
        vecs[11] = '{3'd3, 32'h5, 32'h0, 0, 0,
                     32'h0, 32'h0, 10};
        vecs[12] = '{3'd5, 32'hAAAA, 32'h0, 1, 0,
                     32'hAAAA, 32'h0, 0};
        vecs[13] = '{3'd6, 32'h5555, 32'h0, 0, 1,
                     32'h0, 32'h5555, 0};
        vecs[14] = '{3'd0, 32'hDEAD, 32'hBEEF, 0, 0,
                     32'h0, 32'h0, 0};
        vecs[15] = '{3'd7, 32'hDEAD, 32'hBEEF, 0, 0,
                     32'h0, 32'h0, 0};

        // reset state
        #2 reset = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset stall_req", 32'(stall_req), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wh,
                  vecs[i].wl, vecs[i].vh, vecs[i].vl, vecs[i].n,
                  $sformatf("vec%0d", i));
        end

        // back-to-back MTHI / MTLO
        @(negedge clk);
        start = 1'b1;
        op = 3'd5;
        a = 32'h1234;
        #1;
        chk("mthi stall_req", 32'(stall_req), 32'(0));
        @(negedge clk);
        chk("mthi hi", hi, 32'h1234);
        chk("mthi lo kept", lo, el);
        op = 3'd6;
        a = 32'h5678;
        #1;
        chk("mtlo stall_req", 32'(stall_req), 32'(0));
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        chk("mtlo lo", lo, 32'h5678);
        chk("mtlo hi kept", hi, 32'h1234);
        chk("mt busy", 32'(busy), 32'(0));
        eh = 32'h1234;
        el = 32'h5678;

        // flush mid MULTU, with a start offered on the flush cycle
        @(negedge clk);
        start = 1'b1;
        op = 3'd2;
        a = 32'hFFFFFFFF;
        b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op = 3'd1;
        a = 32'h5;
        b = 32'h6;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        op = 3'd0;
        chk("flush busy", 32'(busy), 32'(0));
        chk("flush done", 32'(done), 32'(0));
        chk("flush hi", hi, eh);
        chk("flush lo", lo, el);
        seen = 1'b0;
        chg = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
            if (hi !== eh || lo !== el) chg = 1'b1;
        end
        chk("flush no late activity", 32'(seen), 32'(0));
        chk("flush no late commit", 32'(chg), 32'(0));

        // start with flush while idle is not accepted
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op = 3'd3;
        a = 32'h9;
        b = 32'h3;
        #1;
        chk("idle flush stall_req", 32'(stall_req), 32'(0));
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        op = 3'd0;
        chk("idle flush busy", 32'(busy), 32'(0));
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("idle flush no op", 32'(seen), 32'(0));
        chk("idle flush hi", hi, eh);
        chk("idle flush lo", lo, el);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            if (cyc == 4) begin
                start = 1'b1;
                op = 3'd1;
                a = 32'h5;
                b = 32'h6;
                #1;
                chk("busy offer stall_req", 32'(stall_req), 32'(1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy offer cycles", cyc, 10);
        chk("busy offer hi", hi, 32'd2);
        chk("busy offer lo", lo, 32'd14);
        chk("busy offer done", 32'(done), 32'(1));
        eh = 32'd2;
        el = 32'd14;
        start = 1'b1;
        op = 3'd1;
        a = 32'h5;
        b = 32'h6;
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        chk("represent accepted", 32'(busy), 32'(1));
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        chk("represent cycles", cyc, 5);
        chk("represent hi", hi, 32'h0);
        chk("represent lo", lo, 32'd30);
        eh = 32'h0;
        el = 32'd30;

        // asynchronous reset mid DIV
        @(negedge clk);
        start = 1'b1;
        op = 3'd3;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'(0));
        chk("async rst hi", hi, 32'h0);
        chk("async rst lo", lo, 32'h0);
        chk("async rst done", 32'(done), 32'(0));
        eh = 32'h0;
        el = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("post rst no commit", 32'(seen), 32'(0));
        chk("post rst lo", lo, 32'h0);
        do_op(3'd2, 32'd3, 32'd4, 1'b1, 1'b1, 32'h0, 32'd12, 5,
              "post rst multu");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
